alu_result_stage: RTL

ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

---
 rtl/alu_result_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: buffers ALU results between execute and writeback, evaluates
// the ARM condition field against the architectural flags at acceptance, and owns
// the NZCV flag register.
//
// Build option: define ALU_RESULT_SKID_EN for a 2-entry skid buffer with a
// registered in_ready. When it is undefined, a single register is used and
// in_ready is combinational (!out_valid || out_ready).
//
// Skid buffer states (ALU_RESULT_SKID_EN only):
//   state | meaning
//   EMPTY | no entries held
//   ONE   | head holds one entry
//   TWO   | head and tail both hold entries; upstream is stalled
module alu_result_stage #(
    parameter int BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] alu_c,
    input  logic            alu_n,
    input  logic            alu_z,
    input  logic            alu_c_out,
    input  logic            alu_v,
    input  logic [3:0]      cond,
    input  logic            set_flags,
    input  logic [3:0]      rd,
    input  logic            rd_we,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] out_result,
    output logic [3:0]      out_rd,
    output logic            out_we,
    output logic [3:0]      nzcv
);

    logic [3:0] nzcv_q, nzcv_d;
    logic       accept, retire, pass;

    // Condition code evaluation against the flags as they stand before this edge.
    always_comb begin
        pass = 1'b0;
        case (cond)
            4'h0: pass = nzcv_q[2];
            4'h1: pass = !nzcv_q[2];
            4'h2: pass = nzcv_q[1];
            4'h3: pass = !nzcv_q[1];
            4'h4: pass = nzcv_q[3];
            4'h5: pass = !nzcv_q[3];
            4'h6: pass = nzcv_q[0];
            4'h7: pass = !nzcv_q[0];
            4'h8: pass = nzcv_q[1] && !nzcv_q[2];
            4'h9: pass = !nzcv_q[1] || nzcv_q[2];
            4'hA: pass = (nzcv_q[3] == nzcv_q[0]);
            4'hB: pass = (nzcv_q[3] != nzcv_q[0]);
            4'hC: pass = !nzcv_q[2] && (nzcv_q[3] == nzcv_q[0]);
            4'hD: pass = nzcv_q[2] || (nzcv_q[3] != nzcv_q[0]);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

    assign accept = in_valid && in_ready && !flush;
    assign retire = out_valid && out_ready;

    // Flag register update: only an accepted, condition-passing flag-setting entry writes.
    always_comb begin
        nzcv_d = nzcv_q;
        if (accept && set_flags && pass)
            nzcv_d = {alu_n, alu_z, alu_c_out, alu_v};
    end

    // Flag register.
    always_ff @(posedge clk) begin
        if (rst) nzcv_q <= 4'b0000;
        else     nzcv_q <= nzcv_d;
    end

    assign nzcv = nzcv_q;

`ifdef ALU_RESULT_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic [BITS-1:0] head_result_q, head_result_d, tail_result_q, tail_result_d;
    logic [3:0]      head_rd_q, head_rd_d, tail_rd_q, tail_rd_d;
    logic            head_we_q, head_we_d, tail_we_q, tail_we_d;

    // Next-state and buffer movement; a retire from TWO promotes the tail to head.
    always_comb begin
        state_d       = state_q;
        head_result_d = head_result_q;
        head_rd_d     = head_rd_q;
        head_we_d     = head_we_q;
        tail_result_d = tail_result_q;
        tail_rd_d     = tail_rd_q;
        tail_we_d     = tail_we_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d       = ONE;
                    head_result_d = alu_c;
                    head_rd_d     = rd;
                    head_we_d     = rd_we && pass;
                end
                ONE: begin
                    if (accept && retire) begin
                        head_result_d = alu_c;
                        head_rd_d     = rd;
                        head_we_d     = rd_we && pass;
                    end else if (accept) begin
                        state_d       = TWO;
                        tail_result_d = alu_c;
                        tail_rd_d     = rd;
                        tail_we_d     = rd_we && pass;
                    end else if (retire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (retire) begin
                    state_d       = ONE;
                    head_result_d = tail_result_q;
                    head_rd_d     = tail_rd_q;
                    head_we_d     = tail_we_q;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    // Skid buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= EMPTY;
            in_ready_q    <= 1'b1;
            head_result_q <= '0;
            head_rd_q     <= 4'd0;
            head_we_q     <= 1'b0;
            tail_result_q <= '0;
            tail_rd_q     <= 4'd0;
            tail_we_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            head_result_q <= head_result_d;
            head_rd_q     <= head_rd_d;
            head_we_q     <= head_we_d;
            tail_result_q <= tail_result_d;
            tail_rd_q     <= tail_rd_d;
            tail_we_q     <= tail_we_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_result = head_result_q;
    assign out_rd     = head_rd_q;
    assign out_we     = head_we_q;
`else
    logic            valid_q, valid_d;
    logic [BITS-1:0] result_q, result_d;
    logic [3:0]      rd_q, rd_d;
    logic            we_q, we_d;

    // Single holding register; a new entry may replace one retiring on the same edge.
    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        rd_d     = rd_q;
        we_d     = we_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = alu_c;
            rd_d     = rd;
            we_d     = rd_we && pass;
        end else if (retire) begin
            valid_d = 1'b0;
        end
    end

    // Holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= 4'd0;
            we_q     <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            rd_q     <= rd_d;
            we_q     <= we_d;
        end
    end

    assign in_ready   = !valid_q || out_ready;
    assign out_valid  = valid_q;
    assign out_result = result_q;
    assign out_rd     = rd_q;
    assign out_we     = we_q;
`endif

endmodule
